// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral-bus command initiator: default
// widths, the FSM state encoding and well-known peripheral addresses.
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;
    localparam int BUS_LEN_W  = 4;

    // Memory-mapped LED register on the CPU-side peripheral bus.
    localparam logic [7:0] LED_REG_ADDR = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } bus_init_state_t;

endpackage

// File: rtl/bus_initiator.sv
// Command-driven second master for the CPU-side peripheral bus.
// Accepts burst commands, issues one-cycle read/write strobes per beat and
// returns read data (or echoed write data) on a valid/ready response stream.
//
// Handshakes: every stream (cmd, wd, rsp) transfers on a rising edge where
// both valid and ready are high; the producer holds valid and its payload
// stable until that edge, and ready/valid driven by this block are registered.
//
// Build option: define BUS_INIT_POSTED_WR_EN to make write bursts posted
// (no response beats, wd_ready also offered in ISSUE for back-to-back writes).
module bus_initiator
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_write,
    output logic              rsp_last,
    output logic              busy,
    output logic              bus_write,
    output logic              bus_read,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  BEAT_ONE = LEN_W'(1);

    bus_init_state_t   state_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;

    logic              cmd_ready_q;
    logic              wd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_write_q;
    logic              rsp_last_q;
    logic              busy_q;
    logic              bus_write_q;
    logic              bus_read_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_dout_q;

    // Address and beat index of the following beat (address wraps at 2^ADDR_W).
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  beat_d;
    logic              last_beat;

    assign addr_d    = addr_q + ADDR_ONE;
    assign beat_d    = beat_q + BEAT_ONE;
    assign last_beat = (beat_q == len_q);

    // Burst FSM; every output is produced by a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            cmd_ready_q <= 1'b0;
            wd_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_write_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_dout_q  <= '0;
        end else begin
            // Strobes last exactly one cycle unless re-armed below.
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        len_q       <= cmd_len;
                        beat_q      <= '0;
                        if (cmd_write) begin
                            state_q    <= ST_WDATA;
                            wd_ready_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ISSUE;
                            bus_read_q <= 1'b1;
                            bus_addr_q <= cmd_addr;
                        end
                    end
                end

                ST_WDATA: begin
                    if (wd_valid && wd_ready_q) begin
                        state_q     <= ST_ISSUE;
                        bus_write_q <= 1'b1;
                        bus_addr_q  <= addr_q;
                        bus_dout_q  <= wd_data;
`ifdef BUS_INIT_POSTED_WR_EN
                        // Keep accepting data in ISSUE unless this is the final beat.
                        wd_ready_q  <= !last_beat;
`else
                        wd_ready_q  <= 1'b0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (write_q) begin
`ifdef BUS_INIT_POSTED_WR_EN
                        if (last_beat) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            wd_ready_q  <= 1'b0;
                        end else begin
                            addr_q <= addr_d;
                            beat_q <= beat_d;
                            if (wd_valid && wd_ready_q) begin
                                // Back-to-back beat: strobe again next cycle.
                                bus_write_q <= 1'b1;
                                bus_addr_q  <= addr_d;
                                bus_dout_q  <= wd_data;
                                wd_ready_q  <= (beat_d != len_q);
                            end else begin
                                state_q <= ST_WDATA;
                            end
                        end
`else
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus_dout_q;
                        rsp_write_q <= 1'b1;
                        rsp_last_q  <= last_beat;
`endif
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus_din;
                    rsp_write_q <= 1'b0;
                    rsp_last_q  <= last_beat;
                end

                ST_RESP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            addr_q <= addr_d;
                            beat_q <= beat_d;
                            if (write_q) begin
                                state_q    <= ST_WDATA;
                                wd_ready_q <= 1'b1;
                            end else begin
                                state_q    <= ST_ISSUE;
                                bus_read_q <= 1'b1;
                                bus_addr_q <= addr_d;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wd_ready  = wd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_write = rsp_write_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;
    assign bus_write = bus_write_q;
    assign bus_read  = bus_read_q;
    assign bus_addr  = bus_addr_q;
    assign bus_dout  = bus_dout_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a table of bursts with hand-computed
// latencies and final values, a per-beat scoreboard for strobes and
// responses, and hand-written sequences for reset and busy-command cases.
module tb_bus_initiator;
  import bus_pkg::*;

`ifdef BUS_INIT_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [3:0] cmd_len = 4'h0;
  logic       wd_valid = 1'b0;
  logic       wd_ready;
  logic [7:0] wd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_write;
  logic       rsp_last;
  logic       busy;
  logic       bus_write;
  logic       bus_read;
  logic [7:0] bus_addr;
  logic [7:0] bus_dout;
  logic [7:0] bus_din = 8'h00;

  bus_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_write(rsp_write), .rsp_last(rsp_last), .busy(busy),
    .bus_write(bus_write), .bus_read(bus_read), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din)
  );

  // Peripheral responder: read data appears the cycle after bus_read,
  // filler value otherwise so a mistimed capture is visible.
  function automatic logic [7:0] rd_model(input logic [7:0] a);
    return a ^ 8'h20;
  endfunction

  always @(posedge clk) bus_din <= bus_read ? rd_model(bus_addr) : 8'h5C;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [17:0] exp_strobe_q[$];  // {write, read, addr, dout-if-write}
  logic [9:0]  exp_rsp_q[$];     // {write, last, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_write, rsp_last,
            busy, bus_write, bus_read, bus_addr, bus_dout};
  endfunction

  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] wbase;
    logic [7:0] wstep;
    int         stall_beat;
    int         stall_cyc;
    int         exp_strobe_n;
    int         exp_rsp_n;
    logic [7:0] exp_last_addr;
    logic [7:0] exp_last_data;
    int         exp_rsps;
  } vec_t;

  vec_t vecs[6];
  vec_t hold_vec;

  // Results of the most recent run_burst.
  int         r_strobe_n, r_last_strobe_n, r_rsp_n, r_nrsp, r_wait;
  int         r_stall_n, r_stall_err, r_leak;
  logic [7:0] r_last_addr, r_last_data;

  // ---------------- driver ----------------
  // Called just after a falling edge. Offers the command, feeds write data,
  // consumes responses (optionally stalling one beat) and checks every beat.
  task automatic run_burst(input vec_t v, input bit hold);
    int beats, exp_r, n, sc, rc, wc, stall_ctr;
    bit stall, stalled_prev;
    logic [9:0] held;
    logic [7:0] a, d;
    beats = int'(v.len) + 1;
    exp_r = (v.w && POSTED) ? 0 : beats;
    for (int i = 0; i < beats; i++) begin
      a = 8'(int'(v.addr) + i);
      d = v.w ? 8'(int'(v.wbase) + int'(v.wstep) * (i + 1) - int'(v.wstep)) : rd_model(a);
      exp_strobe_q.push_back({v.w, ~v.w, a, (v.w ? d : 8'h00)});
      if (!(v.w && POSTED)) exp_rsp_q.push_back({v.w, (i == beats - 1), d});
    end
    r_strobe_n = -1; r_last_strobe_n = -1; r_rsp_n = -1; r_nrsp = 0;
    r_stall_n = 0; r_stall_err = 0; r_leak = 0; r_wait = 0;
    r_last_addr = 8'h00; r_last_data = 8'h00;
    while (!cmd_ready && r_wait < 200) begin
      @(negedge clk);
      r_wait++;
    end
    cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.addr; cmd_len = v.len;
    n = 0; sc = 0; rc = 0; wc = 0; stall_ctr = 0; stalled_prev = 1'b0; held = '0;
    while ((sc < beats || rc < exp_r) && n < 400) begin
      @(negedge clk);
      n++;
      if (hold) begin
        cmd_write = hold_vec.w; cmd_addr = hold_vec.addr; cmd_len = hold_vec.len;
        if (cmd_ready) r_leak++;
      end else begin
        cmd_valid = 1'b0;
      end
      if (bus_write || bus_read) begin
        if (r_strobe_n < 0) r_strobe_n = n;
        r_last_strobe_n = n;
        r_last_addr = bus_addr;
        if (bus_write) r_last_data = bus_dout;
        if (stalled_prev) r_stall_err++;
        if (exp_strobe_q.size() == 0) check("extra_strobe", 32'(bus_write | bus_read), 32'd0);
        else check("strobe_beat", {bus_write, bus_read, bus_addr, (bus_write ? bus_dout : 8'h00)},
                   32'(exp_strobe_q.pop_front()));
        sc++;
      end
      wd_valid = v.w && (wc < beats);
      wd_data = 8'(int'(v.wbase) + int'(v.wstep) * wc);
      if (wd_valid && wd_ready) wc++;
      stall = (rc == v.stall_beat) && (stall_ctr < v.stall_cyc);
      rsp_ready = !stall;
      if (rsp_valid) begin
        if (r_rsp_n < 0) r_rsp_n = n;
        if (stall) begin
          if (stall_ctr == 0) held = {rsp_write, rsp_last, rsp_data};
          else if ({rsp_write, rsp_last, rsp_data} !== held) r_stall_err++;
          stall_ctr++;
        end else begin
          if (exp_rsp_q.size() == 0) check("extra_rsp", 32'(rsp_valid), 32'd0);
          else check("rsp_beat", {rsp_write, rsp_last, rsp_data}, 32'(exp_rsp_q.pop_front()));
          r_last_data = rsp_data;
          rc++;
        end
      end
      stalled_prev = rsp_valid && stall;
    end
    r_nrsp = rc;
    r_stall_n = stall_ctr;
    check("burst_strobes", sc, beats);
    check("burst_rsps", rc, exp_r);
    exp_strobe_q.delete();
    exp_rsp_q.delete();
    wd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
    check("idle_after", {busy, rsp_valid, cmd_ready}, 32'b001);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int wr_rsp_n;
    int sc, wc, n, late_hits;
    vec_t v;
    wr_rsp_n = POSTED ? -1 : 3;

    //           w     addr          len    wbase  wstep  stb stc sn rsp_n     last_a  last_d  rsps
    vecs[0] = '{1'b0, LED_REG_ADDR, 4'd0,  8'h00, 8'h00, -1, 0, 1, 3,        8'h80, 8'hA0, 1};
    vecs[1] = '{1'b1, 8'hFE,        4'd2,  8'h11, 8'h11, -1, 0, 2, wr_rsp_n, 8'h00, 8'h33, (POSTED ? 0 : 3)};
    vecs[2] = '{1'b0, 8'h10,        4'd3,  8'h00, 8'h00,  1, 5, 1, 3,        8'h13, 8'h33, 4};
    vecs[3] = '{1'b1, 8'h05,        4'd0,  8'h5A, 8'h00, -1, 0, 2, wr_rsp_n, 8'h05, 8'h5A, (POSTED ? 0 : 1)};
    vecs[4] = '{1'b0, 8'hF8,        4'd15, 8'h00, 8'h00, -1, 0, 1, 3,        8'h07, 8'h27, 16};
    vecs[5] = '{1'b1, 8'h30,        4'd3,  8'h01, 8'h10, -1, 0, 2, wr_rsp_n, 8'h33, 8'h31, (POSTED ? 0 : 4)};
    hold_vec = '{1'b0, 8'h90, 4'd0, 8'h00, 8'h00, -1, 0, 1, 3, 8'h90, 8'hB0, 1};

    // Reset state, then one cycle later the block offers cmd_ready.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {cmd_ready, busy}, 32'b10);

    // Table-driven bursts.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_burst(v, 1'b0);
      check($sformatf("v%0d_strobe_lat", i), r_strobe_n, v.exp_strobe_n);
      check($sformatf("v%0d_rsp_lat", i), r_rsp_n, v.exp_rsp_n);
      check($sformatf("v%0d_last_addr", i), r_last_addr, v.exp_last_addr);
      check($sformatf("v%0d_last_data", i), r_last_data, v.exp_last_data);
      check($sformatf("v%0d_rsp_count", i), r_nrsp, v.exp_rsps);
      if (v.stall_cyc > 0) begin
        check($sformatf("v%0d_stall_cycles", i), r_stall_n, v.stall_cyc);
        check($sformatf("v%0d_stall_stable", i), r_stall_err, 0);
      end
`ifdef BUS_INIT_POSTED_WR_EN
      if (v.w) check($sformatf("v%0d_back_to_back", i), r_last_strobe_n - r_strobe_n, int'(v.len));
`endif
    end

    // cmd_valid held through a busy read burst: no early acceptance,
    // second command taken in the first IDLE cycle.
    v = '{1'b0, 8'h20, 4'd2, 8'h00, 8'h00, -1, 0, 1, 3, 8'h22, 8'h02, 3};
    run_burst(v, 1'b1);
    check("hold_no_early_ready", r_leak, 0);
    check("hold_first_rsps", r_nrsp, 3);
    check("hold_first_last_data", r_last_data, 8'h02);
    check("hold_cmd_valid_high", cmd_valid, 1'b1);
    run_burst(hold_vec, 1'b0);
    check("hold_second_wait", r_wait, 0);
    check("hold_second_data", r_last_data, 8'hB0);

    // Reset one cycle after the second bus_write of a write burst.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd3;
    sc = 0; wc = 0; n = 0;
    while (sc < 2 && n < 100) begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      if (bus_write) begin
        sc++;
        if (sc == 2) check("rst_second_strobe", {bus_addr, bus_dout}, 32'h41A2);
      end
      wd_valid = (wc < 4);
      wd_data = 8'(8'hA1 + wc);
      if (wd_valid && wd_ready) wc++;
      rsp_ready = 1'b1;
    end
    check("rst_second_strobe_seen", sc, 2);
    @(negedge clk);
    rst = 1'b1;
    wd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wd_valid = 1'b0;
    check("rst_mid_burst_outputs", all_outs(), 32'd0);
    late_hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_write || bus_read || rsp_valid || wd_ready) late_hits++;
    end
    check("rst_no_activity", late_hits, 0);
    check("rst_then_idle", {cmd_ready, busy}, 32'b10);
    v = vecs[0];
    run_burst(v, 1'b0);
    check("rst_new_cmd_data", r_last_data, 8'hA0);
    check("rst_new_cmd_lat", r_rsp_n, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Command-driven initiator for the CPU-side peripheral bus: strobed write/read, 8-bit address, 8-bit write data out, 8-bit read data in.
- Takes burst commands from a debug/test controller and issues single-cycle bus strobes.
- Returns read data, or write acknowledges, on a valid/ready response stream.
- Sits beside the CPU as a second bus master. Arbitration is outside this block.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
LEN_W, 4, burst length field width; beats = cmd_len+1 (1..16)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
wd_valid  in  1  write-data beat offered
wd_ready  out  1  write-data beat accepted when both high
wd_data  in  DATA_W  write-data beat
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response consumer ready
rsp_data  out  DATA_W  read data (read) or echoed write data (write)
rsp_write  out  1  response belongs to a write burst
rsp_last  out  1  final beat of burst
busy  out  1  high whenever state != IDLE
bus_write  out  1  one-cycle write strobe
bus_read  out  1  one-cycle read strobe
bus_addr  out  ADDR_W  transaction address
bus_dout  out  DATA_W  write data
bus_din  in  DATA_W  read data, valid the cycle after bus_read

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0. Reset mid-burst aborts it with no further strobes and no responses; the pending wd beat is not consumed.
- States: IDLE, WDATA, ISSUE, CAPTURE, RESP. All outputs are registered.
- IDLE: cmd_ready=1. On handshake, latch write/addr/len and clear the beat counter. Go to WDATA if write, else ISSUE.
- WDATA: wd_ready=1. On handshake, load bus_dout=wd_data and go to ISSUE. Stall indefinitely while wd_valid=0.
- ISSUE: exactly one cycle with bus_write or bus_read high (never both). bus_addr = current address. Read goes to CAPTURE; write goes to RESP.
- CAPTURE: sample bus_din into rsp_data and go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_write and rsp_last stay stable until rsp_ready. On handshake:
  - if last beat, go to IDLE;
  - else increment the address and beat counter, then go to WDATA (write) or ISSUE (read).
- Read latency: cmd handshake in cycle N, bus_read in N+1, bus_din sampled in N+2, rsp_valid from N+3.
- Write latency: cmd handshake N, wd handshake earliest N+1, bus_write N+2, rsp_valid N+3.
- Address increments modulo 2^ADDR_W (0xFF -> 0x00). No burst-boundary check.
- bus_addr and bus_dout hold their last values outside ISSUE.
- cmd_valid while busy is ignored; cmd_ready=0 whenever state != IDLE.
- rsp_last = (beat counter == latched len).

Optional Feature:
- Macro BUS_INIT_POSTED_WR_EN.
- Defined: write bursts produce no response beats. After ISSUE the block goes straight to WDATA, or to IDLE on the last beat. wd_ready is also high in ISSUE for non-last beats, so back-to-back wd_valid gives one bus_write per cycle. rsp_write is never 1.
- Undefined: every write beat produces a RESP beat as described above.

Decomposition:
- Package bus_pkg holds:
  - ADDR_W and DATA_W defaults;
  - state enum bus_init_state_t;
  - address constant LED_REG_ADDR = 8'h80.
- Single module, no sub-module. The FSM and datapath are small enough to stay flat.

Test Plan:
- Read, len 0, addr 0x80; responder model returns 0xA0 the cycle after bus_read -> bus_read high exactly N+1 with bus_addr=0x80; rsp_valid at N+3 with rsp_data=0xA0, rsp_last=1, rsp_write=0.
- Write burst, len 2, addr 0xFE, wd 0x11/0x22/0x33 -> bus_write at addrs 0xFE, 0xFF, 0x00 with matching bus_dout; three responses echoing the data, rsp_last only on the third.
- Read burst len 3 with rsp_ready held low 5 cycles on beat 1 -> rsp_data stable throughout; no bus_read issued until the handshake; 4 responses total.
- Write burst, rst pulsed one cycle after the second bus_write -> next cycle all outputs 0, no further strobes or responses; a new command is accepted afterwards.
- cmd_valid held high during a busy read burst -> cmd_ready stays 0; second command accepted only in the IDLE cycle after the final rsp handshake.
- With BUS_INIT_POSTED_WR_EN: write burst len 3, wd_valid always 1 -> four bus_write strobes on consecutive cycles; rsp_valid never asserted.
